// File: rtl/txuart_arb_pkg.sv
// Shared types and constants for the txuart packet arbiter.
// State encoding, default lock timeout and an index-width helper.
package txuart_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_LOAD = 2'b01,
    ARB_SEND = 2'b10
  } arb_state_t;

  // 16 bauds at 868 clocks per baud
  localparam logic [23:0] TIMEOUT_DEFAULT = 24'd13888;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/txuart_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, with wrap.
// Ports: req (request vector), ptr (last served), winner (index), any_req.
module txuart_rr_pick
  import txuart_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            any_req
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    winner  = '0;
    any_req = |req;
    found   = 1'b0;
    cand    = '0;
    // i = NREQ comes back to ptr itself, so the last owner
    // is only picked when nobody else is asking
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/txuart_arbiter.sv
// Packet-granular round-robin arbiter sharing one txuart among NREQ sources.
// Ports: i_clk, i_reset; i_req_stb/i_req_data/i_req_last in, o_req_ack out;
// o_grant (one-hot owner), o_abort (lock timeout), o_tx_stb/o_tx_data to the
// txuart, i_tx_busy from it.
module txuart_arbiter
  import txuart_arb_pkg::*;
#(
  parameter int          NREQ           = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  localparam int         IW             = idx_w(NREQ)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req_stb,
  input  logic [8*NREQ-1:0] i_req_data,
  input  logic [NREQ-1:0]   i_req_last,
  output logic [NREQ-1:0]   o_req_ack,
  output logic [NREQ-1:0]   o_grant,
  output logic              o_abort,
  output logic              o_tx_stb,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_busy
);

  arb_state_t      state, state_n;
  logic [IW-1:0]   grant, grant_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   winner;
  logic            any_req;
  logic            last_r, last_n;
  logic [23:0]     cnt, cnt_n;
  logic [NREQ-1:0] ack_n, og_n;
  logic            stb_n, abort_n;
  logic [7:0]      data_n;
  logic [7:0]      req_byte [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_byte
    assign req_byte[k] = i_req_data[8*k +: 8];
  end

  txuart_rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (i_req_stb),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      ptr       <= IW'(NREQ - 1);
      last_r    <= 1'b0;
      cnt       <= '0;
      o_req_ack <= '0;
      o_grant   <= '0;
      o_abort   <= 1'b0;
      o_tx_stb  <= 1'b0;
      o_tx_data <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      ptr       <= ptr_n;
      last_r    <= last_n;
      cnt       <= cnt_n;
      o_req_ack <= ack_n;
      o_grant   <= og_n;
      o_abort   <= abort_n;
      o_tx_stb  <= stb_n;
      o_tx_data <= data_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n   = ptr;
    last_n  = last_r;
    cnt_n   = cnt;
    og_n    = o_grant;
    stb_n   = o_tx_stb;
    data_n  = o_tx_data;
    ack_n   = '0;
    abort_n = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        cnt_n = '0;
        if (any_req) begin
          grant_n       = winner;
          og_n          = '0;
          og_n[winner]  = 1'b1;
          state_n       = ARB_LOAD;
        end
      end
      ARB_LOAD: begin
        if (i_req_stb[grant]) begin
          data_n       = req_byte[grant];
          stb_n        = 1'b1;
          last_n       = i_req_last[grant];
          ack_n[grant] = 1'b1;
          cnt_n        = '0;
          state_n      = ARB_SEND;
        end else if (cnt >= TIMEOUT_CYCLES - 24'd1) begin
          // owner went quiet mid-packet: drop the lock
          abort_n = 1'b1;
          ptr_n   = grant;
          og_n    = '0;
          cnt_n   = '0;
          state_n = ARB_IDLE;
        end else if (cnt != '1) begin
          cnt_n = cnt + 24'd1;
        end
      end
      ARB_SEND: begin
        // byte is registered; hold it until txuart takes it
        if (o_tx_stb && !i_tx_busy) begin
          stb_n = 1'b0;
          if (last_r) begin
            ptr_n   = grant;
            og_n    = '0;
            state_n = ARB_IDLE;
          end else begin
            state_n = ARB_LOAD;
          end
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_txuart_arbiter.sv
// Directed bench for txuart_arbiter with a txuart busy model,
// per-requester byte queues and an in-order expected-byte scoreboard.
module tb_txuart_arbiter;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [3:0]  req_stb, req_last, req_ack, grant;
  logic [31:0] req_data;
  logic        abort, tx_stb, tx_busy;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  txuart_arbiter #(.NREQ(4), .TIMEOUT_CYCLES(24'd20)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_req_stb  (req_stb),
    .i_req_data (req_data),
    .i_req_last (req_last),
    .o_req_ack  (req_ack),
    .o_grant    (grant),
    .o_abort    (abort),
    .o_tx_stb   (tx_stb),
    .o_tx_data  (tx_data),
    .i_tx_busy  (tx_busy)
  );

  int total = 0;
  int bad = 0;

  logic [8:0] mem [4][32];
  int head [4];
  int tail [4];
  logic [9:0] exp_q [$];

  int ucnt = 0;
  int busy_len = 10;
  bit force_busy = 1'b0;
  int cyc = 0, acc_cnt = 0, acc_cyc = 0;
  int abort_cyc = 0, abort_cnt = 0, stray = 0;
  int ack_cnt [4];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input int k, input logic [7:0] d,
                           input logic l);
    mem[k][tail[k]] = {l, d};
    tail[k]++;
    exp_q.push_back({2'(k), d});
  endtask

  // One clock: observe at negedge, run models, drive next inputs.
  task automatic tick();
    logic [9:0]  e;
    logic [31:0] eg;
    logic        b;
    @(negedge clk);
    cyc++;
    b = (ucnt != 0) || force_busy;
    tx_busy = b;
    if (tx_stb === 1'b1 && !b) begin
      acc_cnt++;
      acc_cyc = cyc;
      ucnt = busy_len;
      if (exp_q.size() == 0) begin
        chk("sb_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        eg = 32'd1 << e[9:8];
        chk("tx_data", 32'(tx_data), 32'(e[7:0]));
        chk("tx_grant", 32'(grant), eg);
      end
    end else if (ucnt != 0) begin
      ucnt--;
    end
    if (abort === 1'b1) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    for (int k = 0; k < 4; k++) begin
      if (req_ack[k] === 1'b1) begin
        ack_cnt[k]++;
        if (grant[k] !== 1'b1) stray++;
        if (head[k] < tail[k]) head[k]++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (head[k] < tail[k]) begin
        req_stb[k] = 1'b1;
        req_data[8*k +: 8] = mem[k][head[k]][7:0];
        req_last[k] = mem[k][head[k]][8];
      end else begin
        req_stb[k] = 1'b0;
        req_last[k] = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || ucnt != 0 || grant !== 4'b0)
           && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", 32'(grant), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_stb"}, 32'(tx_stb), 32'd0);
    chk({tag, "_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_ack"}, 32'(req_ack), 32'd0);
    chk({tag, "_abort"}, 32'(abort), 32'd0);
  endtask

  initial begin
    int a0, c0, n, viol;
    int ab [4];
    i_reset = 1'b1;
    req_stb = '0;
    req_last = '0;
    req_data = '0;
    tx_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      head[k] = 0;
      tail[k] = 0;
      ack_cnt[k] = 0;
    end

    // reset state
    repeat (3) tick();
    chk_zero("rst");
    i_reset = 1'b0;

    // "Hi\n" from requester 0, latency and completion
    push_byte(0, 8'h48, 1'b0);
    push_byte(0, 8'h69, 1'b0);
    push_byte(0, 8'h0A, 1'b1);
    a0 = ack_cnt[0];
    c0 = acc_cnt;
    tick();
    tick();
    chk("lat_grant", 32'(grant), 32'h1);
    chk("lat_stb_lo", 32'(tx_stb), 32'd0);
    tick();
    chk("lat_stb_hi", 32'(tx_stb), 32'd1);
    drain();
    chk("hi_accepts", 32'(acc_cnt - c0), 32'd3);
    chk("hi_acks", 32'(ack_cnt[0] - a0), 32'd3);

    // contention 1 vs 2 from reset, then rotation
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    push_byte(1, 8'h11, 1'b0);
    push_byte(1, 8'h12, 1'b1);
    push_byte(2, 8'h21, 1'b0);
    push_byte(2, 8'h22, 1'b1);
    drain();
    push_byte(1, 8'h13, 1'b1);
    drain();
    push_byte(2, 8'h23, 1'b1);
    push_byte(1, 8'h14, 1'b1);
    drain();
    chk("rr_stray", 32'(stray), 32'd0);

    // timeout: req 3 stalls mid-packet, req 0 waits
    push_byte(3, 8'h31, 1'b0);
    tick();
    tick();
    chk("to_grant3", 32'(grant), 32'h8);
    push_byte(0, 8'h01, 1'b0);
    push_byte(0, 8'h02, 1'b1);
    n = 0;
    while (abort !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("to_abort", 32'(abort), 32'd1);
    chk("to_latency", 32'(abort_cyc - acc_cyc), 32'd21);
    chk("to_grant0", 32'(grant), 32'd0);
    tick();
    chk("to_regrant", 32'(grant), 32'h1);
    chk("to_pulse", 32'(abort), 32'd0);
    drain();
    chk("to_count", 32'(abort_cnt), 32'd1);
    chk("to_stray", 32'(stray), 32'd0);

    // long txuart busy: byte must be held
    force_busy = 1'b1;
    a0 = ack_cnt[1];
    c0 = acc_cnt;
    push_byte(1, 8'hA5, 1'b1);
    n = 0;
    while (tx_stb !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("stall_stb", 32'(tx_stb), 32'd1);
    viol = 0;
    repeat (100) begin
      tick();
      if (tx_stb !== 1'b1 || tx_data !== 8'hA5) viol++;
    end
    chk("stall_stable", 32'(viol), 32'd0);
    chk("stall_held", 32'(acc_cnt - c0), 32'd0);
    force_busy = 1'b0;
    tick();
    chk("stall_accept", 32'(acc_cnt - c0), 32'd1);
    drain();
    chk("stall_acks", 32'(ack_cnt[1] - a0), 32'd1);

    // reset in the middle of a 4-byte packet
    force_busy = 1'b1;
    push_byte(2, 8'h41, 1'b0);
    push_byte(2, 8'h42, 1'b0);
    push_byte(2, 8'h43, 1'b0);
    push_byte(2, 8'h44, 1'b1);
    n = 0;
    while (tx_stb !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("mid_stb", 32'(tx_stb), 32'd1);
    chk("mid_data", 32'(tx_data), 32'h41);
    i_reset = 1'b1;
    head[2] = tail[2];
    exp_q.delete();
    tick();
    chk_zero("mid_rst");
    i_reset = 1'b0;
    force_busy = 1'b0;
    ucnt = 0;
    push_byte(0, 8'h51, 1'b1);
    push_byte(3, 8'h53, 1'b1);
    drain();

    // all four requesters, two 1-byte packets each
    for (int k = 0; k < 4; k++) ab[k] = ack_cnt[k];
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++)
        push_byte(k, 8'(8'h80 + 16 * k + r), 1'b1);
    drain();
    for (int k = 0; k < 4; k++)
      chk("all_acks", 32'(ack_cnt[k] - ab[k]), 32'd2);
    chk("all_stray", 32'(stray), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
